// File: rtl/fsm_rx_pkg.sv
// rtl/fsm_rx_pkg.sv - shared constants and state encoding for the serial receive path
package fsm_rx_pkg;

    localparam int DATA_W               = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4,
        PARITY    = 3'd5
    } state_t;

endpackage

// File: rtl/lane_deserializer.sv
// rtl/lane_deserializer.sv - lane synchroniser, frame FSM and shift register
// Optional even-parity bit between data bit 7 and stop bit when RX_PARITY_EN is defined.
module lane_deserializer
    import fsm_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic              clk100_i,
    input  logic              rst_i,
    input  logic              lane_i,
    output logic [DATA_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_err_pulse_o,
    output logic              parity_err_pulse_o,
    output logic              busy_o
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic              sync1_q, sync2_q;
    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              lane_s;
    logic              bit_done;
`ifdef RX_PARITY_EN
    logic              par_q, par_d;
    logic              par_bad;
`endif

    assign lane_s   = sync2_q;
    assign bit_done = (cnt_q == BIT_LAST);
    assign byte_o   = shift_q;
    assign busy_o   = (state_q != IDLE);
`ifdef RX_PARITY_EN
    assign par_bad  = ^{shift_q, par_q};
`endif

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= lane_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        idx_d              = idx_q;
        shift_d            = shift_q;
        byte_valid_o       = 1'b0;
        frame_err_pulse_o  = 1'b0;
        parity_err_pulse_o = 1'b0;
`ifdef RX_PARITY_EN
        par_d              = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!lane_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                // Mid-bit check rejects short low glitches on an idle line
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = lane_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = lane_s;
                    if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    par_d   = lane_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
`ifdef RX_PARITY_EN
                    parity_err_pulse_o = par_bad;
                    byte_valid_o       = lane_s && !par_bad;
`else
                    byte_valid_o       = lane_s;
`endif
                    if (lane_s) begin
                        state_d = IDLE;
                    end else begin
                        frame_err_pulse_o = 1'b1;
                        state_d           = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (lane_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/fsm_rx_with_fifo.sv
// rtl/fsm_rx_with_fifo.sv - serial byte receiver feeding a byte FIFO with sticky error flags
// Optional parity checking and parity_err_o port when RX_PARITY_EN is defined.
module fsm_rx_with_fifo
    import fsm_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 16
) (
    input  logic              clk100_i,
    input  logic              rst_i,
    input  logic              lane_i,
    input  logic              re_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              rx_busy_o,
    output logic              overflow_o,
    output logic              frame_err_o
`ifdef RX_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid, ferr_pulse, perr_pulse;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
    logic              pop_ok, push_ok;

    lane_deserializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_deser (
        .clk100_i           (clk100_i),
        .rst_i              (rst_i),
        .lane_i             (lane_i),
        .byte_o             (rx_byte),
        .byte_valid_o       (rx_valid),
        .frame_err_pulse_o  (ferr_pulse),
        .parity_err_pulse_o (perr_pulse),
        .busy_o             (rx_busy_o)
    );

    always_comb begin
        pop_ok   = re_i && !empty_q;
        // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
        push_ok  = rx_valid && (!full_q || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        data_d   = pop_ok ? mem_q[rd_ptr_q] : data_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        ovf_d   = (ovf_q  && !clr_i) || (rx_valid && !push_ok);
        ferr_d  = (ferr_q && !clr_i) || ferr_pulse;
        perr_d  = (perr_q && !clr_i) || perr_pulse;
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk100_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_byte;
    end

    assign data_o      = data_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;
`ifdef RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_fsm_rx_with_fifo.sv
// tb/tb_fsm_rx_with_fifo.sv - self-checking bench for fsm_rx_with_fifo with a queue reference model
// Also exercises the parity path when RX_PARITY_EN is defined.
module tb_fsm_rx_with_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk100_i = 1'b0;
    logic       rst_i    = 1'b1;
    logic       lane_i   = 1'b1;
    logic       re_i     = 1'b0;
    logic       clr_i    = 1'b0;
    logic [7:0] data_o;
    logic       empty_o, full_o, rx_busy_o, overflow_o, frame_err_o;
`ifdef RX_PARITY_EN
    logic       parity_err_o;
    bit         par_flip_g = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] q_model[$];
    logic [7:0] last_pop;
    bit         exp_ovf, exp_ferr;

    fsm_rx_with_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk100_i    (clk100_i),
        .rst_i       (rst_i),
        .lane_i      (lane_i),
        .re_i        (re_i),
        .clr_i       (clr_i),
        .data_o      (data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .rx_busy_o   (rx_busy_o),
        .overflow_o  (overflow_o),
        .frame_err_o (frame_err_o)
`ifdef RX_PARITY_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );

    always #5 clk100_i = ~clk100_i;

    task automatic tick();
        @(posedge clk100_i);
        #1;
    endtask

    // Frame on the wire: start 0, data LSB first, [even parity], stop
    task automatic send_frame(input logic [7:0] b, input bit stop_b);
        lane_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            lane_i = b[i];
            repeat (CPB) tick();
        end
`ifdef RX_PARITY_EN
        lane_i = (^b) ^ par_flip_g;
        repeat (CPB) tick();
`endif
        lane_i = stop_b;
        repeat (CPB) tick();
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q_model.size() < DEPTH) q_model.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic pulse_pop();
        re_i = 1'b1;
        tick();
        re_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_o); end
        total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full_o); end
        total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", rx_busy_o); end
        total++; if ({overflow_o, frame_err_o} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {overflow_o, frame_err_o}); end
`ifdef RX_PARITY_EN
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err_o); end
`endif
    endtask

    task automatic test_single();
        int n = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (empty_o === 1'b1 && n < 200) begin
                    tick();
                    n++;
                end
            end
        join
        model_push(8'hA5);
        total++;
        if (n < 76 || n > 84) begin bad++; $display("FAIL single_latency got=%0d want=76..84", n); end
        pulse_pop();
        last_pop = q_model.pop_front();
        total++; if (data_o !== last_pop) begin bad++; $display("FAIL single_data got=%h want=%h", data_o, last_pop); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", empty_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            send_frame(seq[i], 1'b1);
            model_push(seq[i]);
        end
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            pulse_pop();
            last_pop = q_model.pop_front();
            total++; if (data_o !== last_pop) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, data_o, last_pop); end
        end
        total++; if ({overflow_o, frame_err_o} !== 2'b00) begin bad++; $display("FAIL b2b_flags got=%b want=00", {overflow_o, frame_err_o}); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty_o); end
    endtask

    task automatic test_glitch();
        lane_i = 1'b0;
        repeat (2) tick();
        lane_i = 1'b1;
        repeat (40) tick();
        total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", rx_busy_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL glitch_empty got=%b want=1", empty_o); end
        total++; if ({overflow_o, frame_err_o} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b want=00", {overflow_o, frame_err_o}); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i));
        end
        repeat (4) tick();
        total++; if (full_o !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", full_o); end
        total++; if (overflow_o !== exp_ovf) begin bad++; $display("FAIL ovf_flag got=%b want=%b", overflow_o, exp_ovf); end
        for (int i = 0; i < 4; i++) begin
            pulse_pop();
            last_pop = q_model.pop_front();
            total++; if (data_o !== last_pop) begin bad++; $display("FAIL ovf_pop%0d got=%h want=%h", i, data_o, last_pop); end
        end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b want=1", empty_o); end
        pulse_pop();
        total++; if (data_o !== last_pop) begin bad++; $display("FAIL ovf_pop_empty got=%h want=%h", data_o, last_pop); end
        pulse_clr();
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow_o); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0);
        exp_ferr = 1'b1;
        repeat (40) tick();
        total++; if (frame_err_o !== exp_ferr) begin bad++; $display("FAIL ferr_flag got=%b want=1", frame_err_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL ferr_empty got=%b want=1", empty_o); end
        total++; if (rx_busy_o !== 1'b1) begin bad++; $display("FAIL ferr_busy_low got=%b want=1", rx_busy_o); end
        lane_i = 1'b1;
        repeat (5) tick();
        total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL ferr_busy_high got=%b want=0", rx_busy_o); end
        pulse_clr();
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%b want=0", frame_err_o); end
    endtask

    task automatic test_reset_mid_frame();
        lane_i = 1'b0;
        repeat (CPB) tick();
        lane_i = 1'b1;
        repeat (3 * CPB) tick();
        rst_i = 1'b1;
        #2;
        total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", rx_busy_o); end
        tick();
        rst_i = 1'b0;
        q_model.delete();
        last_pop = 8'h00;
        repeat (5 * CPB) tick();
        total++; if ({rx_busy_o, empty_o} !== 2'b01) begin bad++; $display("FAIL midrst_idle got=%b want=01", {rx_busy_o, empty_o}); end
        send_frame(8'hC3, 1'b1);
        model_push(8'hC3);
        repeat (4) tick();
        pulse_pop();
        last_pop = q_model.pop_front();
        total++; if (data_o !== last_pop) begin bad++; $display("FAIL midrst_data got=%h want=%h", data_o, last_pop); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int nf = $urandom_range(1, 5);
            int np = $urandom_range(0, 6);
            for (int f = 0; f < nf; f++) begin
                logic [7:0] b = 8'($urandom);
                bit good = ($urandom_range(0, 5) != 0);
                send_frame(b, good);
                if (good) model_push(b);
                else exp_ferr = 1'b1;
                lane_i = 1'b1;
                repeat ($urandom_range(good ? 0 : CPB, 20)) tick();
            end
            repeat (4) tick();
            total++; if (full_o !== (q_model.size() == DEPTH)) begin bad++; $display("FAIL rnd_full r=%0d got=%b want=%b", r, full_o, q_model.size() == DEPTH); end
            total++; if (overflow_o !== exp_ovf) begin bad++; $display("FAIL rnd_ovf r=%0d got=%b want=%b", r, overflow_o, exp_ovf); end
            total++; if (frame_err_o !== exp_ferr) begin bad++; $display("FAIL rnd_ferr r=%0d got=%b want=%b", r, frame_err_o, exp_ferr); end
            for (int p = 0; p < np; p++) begin
                pulse_pop();
                if (q_model.size() != 0) last_pop = q_model.pop_front();
                total++; if (data_o !== last_pop) begin bad++; $display("FAIL rnd_data r=%0d p=%0d got=%h want=%h", r, p, data_o, last_pop); end
                total++; if (empty_o !== (q_model.size() == 0)) begin bad++; $display("FAIL rnd_empty r=%0d p=%0d got=%b want=%b", r, p, empty_o, q_model.size() == 0); end
            end
            pulse_clr();
        end
        while (q_model.size() != 0) begin
            pulse_pop();
            last_pop = q_model.pop_front();
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        par_flip_g = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip_g = 1'b0;
        repeat (4) tick();
        total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL par_err got=%b want=1", parity_err_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL par_drop got=%b want=1", empty_o); end
        pulse_clr();
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL par_clr got=%b want=0", parity_err_o); end
        send_frame(8'h07, 1'b1);
        model_push(8'h07);
        repeat (4) tick();
        pulse_pop();
        last_pop = q_model.pop_front();
        total++; if (data_o !== last_pop) begin bad++; $display("FAIL par_data got=%h want=%h", data_o, last_pop); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL par_ok_flag got=%b want=0", parity_err_o); end
    endtask
`endif

    initial begin
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        last_pop = 8'h00;
        repeat (3) tick();
        test_reset();
        rst_i = 1'b0;
        repeat (4) tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_overflow();
        test_frame_err();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
